// File: rtl/sm3_ctrl.sv
// SM3 message controller: packs 32-bit big-endian words into 512-bit blocks, pads them,
// appends the 64-bit bit length, drives the compression core once per block and returns the digest.
module sm3_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         msg_valid,
   output logic         msg_ready,
   input  logic [31:0]  msg_data,
   input  logic         msg_last,
   input  logic [2:0]   msg_nbytes,
   output logic         cf_start,
   output logic [255:0] cf_v,
   output logic [511:0] cf_b,
   input  logic         cf_done,
   input  logic [255:0] cf_v_res,
   output logic         digest_valid,
   output logic [255:0] digest,
   input  logic         digest_ready
);

   localparam logic [255:0] IV =
      256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_RUN, S_OUT} state_e;

   state_e        state_q;
   logic          msg_ready_q;
   logic          cf_start_q;
   logic          digest_valid_q;
   logic [255:0]  digest_q;
   logic [255:0]  v_q;
   logic [63:0]   bitlen_q;
   logic [4:0]    widx_q;
   logic          pad80_done_q;
   logic          len_pend_q;
   logic          len_hi_q;
   logic          msg_done_q;
   logic [31:0]   buf_q [16];

   logic          accept;
   logic [31:0]   in_word_d;
   logic          pad_in_d;
   logic [63:0]   in_bits_d;
   logic [31:0]   pad_word_d;

   assign accept = msg_valid & msg_ready_q;

   // A short last word gets its 0x80 marker in place, so no separate marker word is needed.
   always_comb begin
      in_word_d = msg_data;
      pad_in_d  = 1'b0;
      if (msg_last) begin
         case (msg_nbytes)
            3'd1: begin in_word_d = {msg_data[31:24], 24'h800000}; pad_in_d = 1'b1; end
            3'd2: begin in_word_d = {msg_data[31:16], 16'h8000};   pad_in_d = 1'b1; end
            3'd3: begin in_word_d = {msg_data[31:8], 8'h80};       pad_in_d = 1'b1; end
            default: in_word_d = msg_data;
         endcase
      end
      in_bits_d = msg_last ? {58'd0, msg_nbytes, 3'd0} : 64'd32;
   end

   // len_hi_q marks that word 14 of this block took the upper length half, so word 15 takes the lower.
   always_comb begin
      pad_word_d = 32'h0;
      if (!pad80_done_q)
         pad_word_d = 32'h8000_0000;
      else if (len_pend_q && widx_q == 5'd14)
         pad_word_d = bitlen_q[63:32];
      else if (len_hi_q && widx_q == 5'd15)
         pad_word_d = bitlen_q[31:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         msg_ready_q    <= 1'b0;
         cf_start_q     <= 1'b0;
         digest_valid_q <= 1'b0;
         digest_q       <= '0;
         v_q            <= IV;
         bitlen_q       <= '0;
         widx_q         <= '0;
         pad80_done_q   <= 1'b0;
         len_pend_q     <= 1'b0;
         len_hi_q       <= 1'b0;
         msg_done_q     <= 1'b0;
         for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      end else begin
         cf_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               msg_ready_q <= 1'b1;
               if (accept) begin
                  v_q          <= IV;
                  bitlen_q     <= in_bits_d;
                  buf_q[0]     <= in_word_d;
                  widx_q       <= 5'd1;
                  msg_done_q   <= msg_last;
                  len_pend_q   <= msg_last;
                  pad80_done_q <= pad_in_d;
                  len_hi_q     <= 1'b0;
                  if (msg_last) begin
                     msg_ready_q <= 1'b0;
                     state_q     <= S_PAD;
                  end else begin
                     state_q     <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (accept) begin
                  buf_q[widx_q[3:0]] <= in_word_d;
                  widx_q             <= widx_q + 5'd1;
                  bitlen_q           <= bitlen_q + in_bits_d;
                  if (msg_last) begin
                     msg_done_q   <= 1'b1;
                     len_pend_q   <= 1'b1;
                     pad80_done_q <= pad_in_d;
                  end
                  // A full block always goes to the core first; any padding follows in the next block.
                  if (widx_q == 5'd15) begin
                     msg_ready_q <= 1'b0;
                     cf_start_q  <= 1'b1;
                     state_q     <= S_RUN;
                  end else if (msg_last) begin
                     msg_ready_q <= 1'b0;
                     state_q     <= S_PAD;
                  end
               end
            end
            S_PAD: begin
               buf_q[widx_q[3:0]] <= pad_word_d;
               widx_q             <= widx_q + 5'd1;
               pad80_done_q       <= 1'b1;
               if (pad80_done_q && len_pend_q && widx_q == 5'd14) len_hi_q <= 1'b1;
               if (len_hi_q && widx_q == 5'd15) begin
                  len_hi_q   <= 1'b0;
                  len_pend_q <= 1'b0;
               end
               if (widx_q == 5'd15) begin
                  cf_start_q <= 1'b1;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               if (!cf_start_q && cf_done) begin
                  v_q    <= cf_v_res;
                  widx_q <= '0;
                  if (!msg_done_q) begin
                     msg_ready_q <= 1'b1;
                     state_q     <= S_LOAD;
                  end else if (len_pend_q) begin
                     state_q     <= S_PAD;
                  end else begin
                     digest_valid_q <= 1'b1;
                     digest_q       <= cf_v_res;
                     state_q        <= S_OUT;
                  end
               end
            end
            S_OUT: begin
               if (digest_ready) begin
                  digest_valid_q <= 1'b0;
                  msg_ready_q    <= 1'b1;
                  state_q        <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_cf_b
      assign cf_b[511-32*i -: 32] = buf_q[i];
   end

   assign msg_ready    = msg_ready_q;
   assign cf_start     = cf_start_q;
   assign cf_v         = v_q;
   assign digest_valid = digest_valid_q;
   assign digest       = digest_q;

endmodule

// File: tb/tb_sm3_ctrl.sv
// Bench for sm3_ctrl: behavioural SM3 compression core, byte-level reference hash,
// table of messages, digest scoreboard and reset-abort sequence.
module tb_sm3_ctrl;

   localparam logic [255:0] IV =
      256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         msg_valid = 1'b0;
   logic         msg_ready;
   logic [31:0]  msg_data = '0;
   logic         msg_last = 1'b0;
   logic [2:0]   msg_nbytes = '0;
   logic         cf_start;
   logic [255:0] cf_v;
   logic [511:0] cf_b;
   logic         cf_done = 1'b0;
   logic [255:0] cf_v_res = '0;
   logic         digest_valid;
   logic [255:0] digest;
   logic         digest_ready = 1'b0;

   sm3_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
      .msg_last(msg_last), .msg_nbytes(msg_nbytes),
      .cf_start(cf_start), .cf_v(cf_v), .cf_b(cf_b),
      .cf_done(cf_done), .cf_v_res(cf_v_res),
      .digest_valid(digest_valid), .digest(digest), .digest_ready(digest_ready)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [255:0] exp_q[$];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- SM3 reference ----------------
   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
   endfunction
   function automatic logic [31:0] p0(input logic [31:0] x);
      return x ^ rol(x, 9) ^ rol(x, 17);
   endfunction
   function automatic logic [31:0] p1(input logic [31:0] x);
      return x ^ rol(x, 15) ^ rol(x, 23);
   endfunction

   function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
      logic [31:0] w [68];
      logic [31:0] w1 [64];
      logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, ff, gg;
      for (int j = 0; j < 16; j++) w[j] = blk[511-32*j -: 32];
      for (int j = 16; j < 68; j++)
         w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
      for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
      {a, b, c, d, e, f, g, h} = v;
      for (int j = 0; j < 64; j++) begin
         tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
         ss1 = rol(rol(a, 12) + e + rol(tj, j % 32), 7);
         ss2 = ss1 ^ rol(a, 12);
         ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
         gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
         tt1 = ff + d + ss2 + w1[j];
         tt2 = gg + h + ss1 + w[j];
         d = c; c = rol(b, 9); b = a; a = tt1;
         h = g; g = rol(f, 19); f = e; e = p0(tt2);
      end
      return {a, b, c, d, e, f, g, h} ^ v;
   endfunction

   logic [31:0] mw [0:63];
   int          mw_n;
   int          mw_nb;

   // Byte-oriented padding, independent of how the controller lays out words.
   function automatic logic [255:0] sm3_ref();
      logic [7:0]   mb [0:1023];
      logic [63:0]  bl;
      logic [255:0] v;
      logic [511:0] blk;
      int n, nb;
      n = 0;
      for (int i = 0; i < mw_n; i++) begin
         nb = (i == mw_n - 1) ? mw_nb : 4;
         for (int k = 0; k < nb; k++) begin mb[n] = mw[i][31-8*k -: 8]; n++; end
      end
      bl = 64'(n) * 64'd8;
      mb[n] = 8'h80; n++;
      while (n % 64 != 56) begin mb[n] = 8'h00; n++; end
      for (int k = 0; k < 8; k++) begin mb[n] = bl[63-8*k -: 8]; n++; end
      v = IV;
      for (int base = 0; base < n; base += 64) begin
         for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = mb[base+k];
         v = sm3_cf(v, blk);
      end
      return v;
   endfunction

   // ---------------- compression core model ----------------
   logic         core_busy = 1'b0;
   int           core_cnt = 0;
   int           dmin = 1, dmax = 1;
   int           start_cnt = 0;
   logic [511:0] cap_b;
   logic [255:0] cap_v, core_res;
   logic [511:0] blk_log[$];

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_busy = 1'b0;
         core_cnt  = 0;
         cf_done   = 1'b0;
      end else if (cf_start) begin
         check("single_start", 512'(core_busy), 512'(0));
         start_cnt++;
         blk_log.push_back(cf_b);
         cap_b     = cf_b;
         cap_v     = cf_v;
         core_res  = sm3_cf(cf_v, cf_b);
         cf_done   = 1'b0;
         core_busy = 1'b1;
         core_cnt  = int'($urandom_range(dmax, dmin));
      end else if (core_busy) begin
         check("cf_b_stable", cf_b, cap_b);
         check("cf_v_stable", 512'(cf_v), 512'(cap_v));
         core_cnt--;
         if (core_cnt <= 0) begin
            cf_v_res  = core_res;
            cf_done   = 1'b1;
            core_busy = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [31:0] data, input logic last, input int nb);
      int waited;
      msg_valid  = 1'b1;
      msg_data   = data;
      msg_last   = last;
      msg_nbytes = last ? 3'(nb) : 3'($urandom_range(7, 0));
      waited = 0;
      while (!msg_ready && waited < 2000) begin @(negedge clk); waited++; end
      check("msg_accept", 512'(msg_ready), 512'(1));
      @(negedge clk);
      msg_valid = 1'b0;
      msg_last  = 1'b0;
   endtask

   task automatic get_digest(input int hold);
      int waited;
      logic [255:0] first, got;
      waited = 0;
      while (!digest_valid && waited < 6000) begin @(negedge clk); waited++; end
      check("digest_valid_arrives", 512'(digest_valid), 512'(1));
      first = digest;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("digest_hold_valid", 512'(digest_valid), 512'(1));
         check("digest_hold_stable", 512'(digest), 512'(first));
      end
      digest_ready = 1'b1;
      got = digest;
      @(negedge clk);
      digest_ready = 1'b0;
      check("digest", 512'(got), 512'(exp_q.pop_front()));
      check("digest_valid_drop", 512'(digest_valid), 512'(0));
   endtask

   task automatic check_reset_outputs();
      check("rst_msg_ready", 512'(msg_ready), 512'(0));
      check("rst_cf_start", 512'(cf_start), 512'(0));
      check("rst_cf_v", 512'(cf_v), 512'(IV));
      check("rst_cf_b", cf_b, 512'(0));
      check("rst_digest_valid", 512'(digest_valid), 512'(0));
      check("rst_digest", 512'(digest), 512'(0));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int           nwords;
      int           nbytes;      // 0 picks 1..4 at random
      logic [31:0]  fill;
      bit           rnd;
      bit           known;
      logic [255:0] exp_digest;
      bit           chk_len;
      int           gap_max;
      int           hold;
      int           dmin;
      int           dmax;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input int nw, input int nb, input logic [31:0] fill, input bit rnd,
                               input bit known, input logic [255:0] dg, input bit chk_len,
                               input int gap, input int hold, input int d0, input int d1);
      vec_t v;
      v.nwords = nw; v.nbytes = nb; v.fill = fill; v.rnd = rnd; v.known = known;
      v.exp_digest = dg; v.chk_len = chk_len; v.gap_max = gap; v.hold = hold;
      v.dmin = d0; v.dmax = d1;
      return v;
   endfunction

   task automatic run_vec(input vec_t vc);
      int len, exp_blk, base, s0;
      logic [255:0] exp_d;
      mw_n  = vc.nwords;
      mw_nb = (vc.nbytes == 0) ? int'($urandom_range(4, 1)) : vc.nbytes;
      for (int i = 0; i < mw_n; i++) mw[i] = vc.rnd ? $urandom : vc.fill;
      exp_d = vc.known ? vc.exp_digest : sm3_ref();
      exp_q.push_back(exp_d);
      len     = (mw_n - 1) * 4 + mw_nb;
      exp_blk = (len + 9 + 63) / 64;
      base = blk_log.size();
      s0   = start_cnt;
      dmin = vc.dmin;
      dmax = vc.dmax;
      for (int i = 0; i < mw_n; i++) begin
         repeat ($urandom_range(vc.gap_max, 0)) @(negedge clk);
         send_word(mw[i], i == mw_n - 1, mw_nb);
      end
      get_digest(vc.hold);
      check("block_count", 512'(start_cnt - s0), 512'(exp_blk));
      if (vc.chk_len) begin
         check("blk_log_depth", 512'(blk_log.size() >= base + 2), 512'(1));
         if (blk_log.size() >= base + 2) begin
            check("blk1_w14", 512'(blk_log[base][63:32]),   512'(32'h8000_0000));
            check("blk1_w15", 512'(blk_log[base][31:0]),    512'(32'h0));
            check("blk2_w14", 512'(blk_log[base+1][63:32]), 512'(32'h0));
            check("blk2_w15", 512'(blk_log[base+1][31:0]),  512'(32'h1c0));
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int s0;
      vecs[0] = mk(1, 3, 32'h61626300, 0, 1,
                   256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0,
                   0, 0, 0, 1, 1);
      vecs[1] = mk(16, 4, 32'h61626364, 0, 1,
                   256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732,
                   0, 0, 0, 2, 5);
      vecs[2] = mk(14, 4, 32'h61626364, 0, 0, '0, 1, 0, 0, 1, 3);
      vecs[3] = mk(21, 0, '0, 1, 0, '0, 0, 3, 20, 1, 4);
      vecs[4] = mk(15, 4, '0, 1, 0, '0, 0, 1, 5, 70, 200);
      vecs[5] = mk(14, 3, '0, 1, 0, '0, 0, 2, 2, 1, 3);
      vecs[6] = mk(15, 2, '0, 1, 0, '0, 0, 2, 0, 1, 3);
      vecs[7] = mk(16, 1, '0, 1, 0, '0, 0, 2, 0, 1, 3);
      vecs[8] = mk(32, 4, '0, 1, 0, '0, 0, 2, 20, 1, 6);
      vecs[9] = mk(1, 4, '0, 1, 0, '0, 0, 0, 3, 1, 2);

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      #1 check("ready_low_before_edge", 512'(msg_ready), 512'(0));
      @(negedge clk);
      check("ready_after_reset", 512'(msg_ready), 512'(1));

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Abort mid-block at widx=7.
      for (int i = 0; i < 7; i++) send_word($urandom, 1'b0, 4);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      s0 = start_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("no_start_after_reset", 512'(start_cnt - s0), 512'(0));
      check("no_digest_after_reset", 512'(digest_valid), 512'(0));
      run_vec(vecs[0]);

      check("scoreboard_empty", 512'(exp_q.size()), 512'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #800000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
